// File: rtl/imem_fetch_controller.sv
// imem_fetch_controller: IF-stage sequencer for a single-port, 1-cycle-latency
// instruction memory. It keeps the fetch PC and issues one read per cycle.
// A one-entry skid buffer absorbs downstream stalls, and redirects flush the
// pipe. The same read port is shared with a debug/loader requester, and that
// requester is guaranteed a grant within a bounded wait.
//
// Ports:
//   clk, rst                  clock; synchronous active-high reset
//   stall                     downstream cannot accept; hold output registers
//   redirect, redirect_target branch/jump flush and new PC (bits [1:0] ignored)
//   imem_address, imem_read_en  read request to memory (combinational)
//   imem_instruction          memory read data, valid the cycle after a read
//   instruction, pc_out,      registered fetched instruction, its address,
//   pc_plus4, instr_valid     address + 4, and valid flag
//   dbg_req, dbg_addr         debug read request (held until granted) + address
//   dbg_grant                 debug owns the read port this cycle (combinational)
//   dbg_data, dbg_valid       debug read data; valid one cycle after the grant
module imem_fetch_controller #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned DBG_MAX_WAIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic [31:0] imem_address,
  output logic        imem_read_en,
  input  logic [31:0] imem_instruction,
  output logic [31:0] instruction,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  output logic        instr_valid,
  input  logic        dbg_req,
  input  logic [31:0] dbg_addr,
  output logic        dbg_grant,
  output logic [31:0] dbg_data,
  output logic        dbg_valid
);

  localparam int unsigned XLEN   = 32;
  localparam int unsigned WAIT_W = (DBG_MAX_WAIT < 1) ? 1 : $clog2(DBG_MAX_WAIT + 1);

  logic [XLEN-1:0]   fetch_pc;
  logic              inflight_valid;
  logic [XLEN-1:0]   inflight_pc;
  logic              skid_valid;
  logic [XLEN-1:0]   skid_instr;
  logic [XLEN-1:0]   skid_pc;
  logic [XLEN-1:0]   dbg_data_q;
  logic [WAIT_W-1:0] wait_cnt;

  logic fetch_ok;
  logic fetch_issue;
  logic wait_at_max;

  // Address low bits are forced to zero, so these bits are intentionally unused.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{dbg_addr[1:0], redirect_target[1:0]};

  // Port arbitration and read request.
  always_comb begin
    wait_at_max  = (wait_cnt == WAIT_W'(DBG_MAX_WAIT));
    fetch_ok     = !rst && !redirect && !stall && !skid_valid;
    dbg_grant    = dbg_req && !rst && (!fetch_ok || wait_at_max);
    fetch_issue  = fetch_ok && !dbg_grant;
    imem_read_en = fetch_issue || dbg_grant;
    imem_address = dbg_grant ? {dbg_addr[XLEN-1:2], 2'b00} : fetch_pc;
  end

  // The debug read data is passed straight through while it is valid.
  // After that, the captured copy is shown, so the output stays stable between reads.
  assign dbg_data = dbg_valid ? imem_instruction : dbg_data_q;

  // Fetch PC, in-flight tracking, skid buffer, output registers and debug state.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc       <= {RESET_PC[XLEN-1:2], 2'b00};
      inflight_valid <= 1'b0;
      inflight_pc    <= '0;
      skid_valid     <= 1'b0;
      skid_instr     <= '0;
      skid_pc        <= '0;
      instruction    <= '0;
      pc_out         <= '0;
      pc_plus4       <= XLEN'(4);
      instr_valid    <= 1'b0;
      dbg_valid      <= 1'b0;
      dbg_data_q     <= '0;
      wait_cnt       <= '0;
    end else begin
      // The debug in-flight flag doubles as the debug valid output.
      dbg_valid <= dbg_grant;
      if (dbg_valid) begin
        dbg_data_q <= imem_instruction;
      end

      if (dbg_req && !dbg_grant) begin
        if (!wait_at_max) begin
          wait_cnt <= wait_cnt + WAIT_W'(1);
        end
      end else begin
        wait_cnt <= '0;
      end

      // Only fetch reads are tracked here. A debug read leaves this slot empty.
      inflight_valid <= fetch_issue;
      if (fetch_issue) begin
        inflight_pc <= fetch_pc;
      end

      if (redirect) begin
        // Whatever is arriving this cycle is dropped, because the response is not consumed.
        fetch_pc    <= {redirect_target[XLEN-1:2], 2'b00};
        skid_valid  <= 1'b0;
        instr_valid <= 1'b0;
      end else begin
        if (fetch_issue) begin
          fetch_pc <= fetch_pc + XLEN'(4);
        end

        if (inflight_valid) begin
          if (!stall) begin
            instruction <= imem_instruction;
            pc_out      <= inflight_pc;
            pc_plus4    <= inflight_pc + XLEN'(4);
            instr_valid <= 1'b1;
          end else begin
            skid_valid <= 1'b1;
            skid_instr <= imem_instruction;
            skid_pc    <= inflight_pc;
          end
        end else if (!stall) begin
          if (skid_valid) begin
            instruction <= skid_instr;
            pc_out      <= skid_pc;
            pc_plus4    <= skid_pc + XLEN'(4);
            instr_valid <= 1'b1;
            skid_valid  <= 1'b0;
          end else begin
            instr_valid <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_fetch_controller.sv
// Directed, table-driven bench for imem_fetch_controller. The memory model
// returns word k = 0x1000 + k, one cycle after each read.
module tb_imem_fetch_controller;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] imem_address;
  logic        imem_read_en;
  logic [31:0] imem_instruction;
  logic [31:0] instruction;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        instr_valid;
  logic        dbg_req;
  logic [31:0] dbg_addr;
  logic        dbg_grant;
  logic [31:0] dbg_data;
  logic        dbg_valid;

  int total = 0;
  int bad   = 0;

  imem_fetch_controller #(
    .RESET_PC    (32'h0000_0000),
    .DBG_MAX_WAIT(8)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .imem_address    (imem_address),
    .imem_read_en    (imem_read_en),
    .imem_instruction(imem_instruction),
    .instruction     (instruction),
    .pc_out          (pc_out),
    .pc_plus4        (pc_plus4),
    .instr_valid     (instr_valid),
    .dbg_req         (dbg_req),
    .dbg_addr        (dbg_addr),
    .dbg_grant       (dbg_grant),
    .dbg_data        (dbg_data),
    .dbg_valid       (dbg_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memory model
  initial imem_instruction = 32'h0;
  always @(posedge clk) begin
    if (imem_read_en) imem_instruction <= 32'h1000 + (imem_address >> 2);
  end

  typedef struct {
    bit          rst;
    bit          stall;
    bit          redirect;
    logic [31:0] target;
    bit          dreq;
    logic [31:0] daddr;
    bit          e_rd;
    logic [31:0] e_addr;
    bit          e_grant;
    bit          chk_out;
    bit          e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    bit          e_dv;
    logic [31:0] e_dd;
  } vec_t;

  function automatic vec_t mk(bit r, bit s, bit rd, logic [31:0] t, bit dq, logic [31:0] da,
                              bit erd, logic [31:0] ea, bit eg, bit co, bit ev,
                              logic [31:0] ep, logic [31:0] ei, bit edv, logic [31:0] edd);
    vec_t v;
    v.rst = r; v.stall = s; v.redirect = rd; v.target = t; v.dreq = dq; v.daddr = da;
    v.e_rd = erd; v.e_addr = ea; v.e_grant = eg; v.chk_out = co; v.e_valid = ev;
    v.e_pc = ep; v.e_instr = ei; v.e_dv = edv; v.e_dd = edd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then check the outputs at the falling edge.
  task automatic apply(input vec_t v, input string tag);
    rst = v.rst; stall = v.stall; redirect = v.redirect; redirect_target = v.target;
    dbg_req = v.dreq; dbg_addr = v.daddr;
    @(negedge clk);
    chk({tag, " rd_en"}, 32'(imem_read_en), 32'(v.e_rd));
    if (v.e_rd) chk({tag, " addr"}, imem_address, v.e_addr);
    chk({tag, " grant"}, 32'(dbg_grant), 32'(v.e_grant));
    if (v.chk_out) begin
      chk({tag, " valid"}, 32'(instr_valid), 32'(v.e_valid));
      if (v.e_valid) begin
        chk({tag, " pc"}, pc_out, v.e_pc);
        chk({tag, " instr"}, instruction, v.e_instr);
        chk({tag, " pc4"}, pc_plus4, v.e_pc + 32'd4);
      end
      chk({tag, " dbg_valid"}, 32'(dbg_valid), 32'(v.e_dv));
      if (v.e_dv) chk({tag, " dbg_data"}, dbg_data, v.e_dd);
    end
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " rst valid"}, 32'(instr_valid), 32'h0);
    chk({tag, " rst pc"}, pc_out, 32'h0);
    chk({tag, " rst instr"}, instruction, 32'h0);
    chk({tag, " rst pc4"}, pc_plus4, 32'h4);
    chk({tag, " rst dbg_valid"}, 32'(dbg_valid), 32'h0);
    chk({tag, " rst dbg_data"}, dbg_data, 32'h0);
    chk({tag, " rst rd_en"}, 32'(imem_read_en), 32'h0);
    chk({tag, " rst grant"}, 32'(dbg_grant), 32'h0);
  endtask

  vec_t vecs[21];

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_target = 32'h0;
    dbg_req = 1'b0; dbg_addr = 32'h0;

    // Streaming, 3-cycle stall, redirect during stall, debug read during stall
    //              rst st rd target       dq daddr     rd addr          g  co v  pc            instr          dv dd
    vecs[0]  = mk(0, 0, 0, 32'h0,        0, 32'h0,    1, 32'h00,       0, 1, 0, 32'h0,        32'h0,         0, 32'h0);
    vecs[1]  = mk(0, 0, 0, 32'h0,        0, 32'h0,    1, 32'h04,       0, 1, 0, 32'h0,        32'h0,         0, 32'h0);
    vecs[2]  = mk(0, 0, 0, 32'h0,        0, 32'h0,    1, 32'h08,       0, 1, 1, 32'h00,       32'h1000,      0, 32'h0);
    vecs[3]  = mk(0, 0, 0, 32'h0,        0, 32'h0,    1, 32'h0C,       0, 1, 1, 32'h04,       32'h1001,      0, 32'h0);
    vecs[4]  = mk(0, 0, 0, 32'h0,        0, 32'h0,    1, 32'h10,       0, 1, 1, 32'h08,       32'h1002,      0, 32'h0);
    vecs[5]  = mk(0, 1, 0, 32'h0,        0, 32'h0,    0, 32'h0,        0, 1, 1, 32'h0C,       32'h1003,      0, 32'h0);
    vecs[6]  = mk(0, 1, 0, 32'h0,        0, 32'h0,    0, 32'h0,        0, 1, 1, 32'h0C,       32'h1003,      0, 32'h0);
    vecs[7]  = mk(0, 1, 0, 32'h0,        0, 32'h0,    0, 32'h0,        0, 1, 1, 32'h0C,       32'h1003,      0, 32'h0);
    vecs[8]  = mk(0, 0, 0, 32'h0,        0, 32'h0,    0, 32'h0,        0, 1, 1, 32'h0C,       32'h1003,      0, 32'h0);
    vecs[9]  = mk(0, 0, 0, 32'h0,        0, 32'h0,    1, 32'h14,       0, 1, 1, 32'h10,       32'h1004,      0, 32'h0);
    vecs[10] = mk(0, 0, 0, 32'h0,        0, 32'h0,    1, 32'h18,       0, 1, 0, 32'h0,        32'h0,         0, 32'h0);
    vecs[11] = mk(0, 0, 0, 32'h0,        0, 32'h0,    1, 32'h1C,       0, 1, 1, 32'h14,       32'h1005,      0, 32'h0);
    vecs[12] = mk(0, 1, 1, 32'h43,       0, 32'h0,    0, 32'h0,        0, 1, 1, 32'h18,       32'h1006,      0, 32'h0);
    vecs[13] = mk(0, 0, 0, 32'h0,        0, 32'h0,    1, 32'h40,       0, 1, 0, 32'h0,        32'h0,         0, 32'h0);
    vecs[14] = mk(0, 0, 0, 32'h0,        0, 32'h0,    1, 32'h44,       0, 1, 0, 32'h0,        32'h0,         0, 32'h0);
    vecs[15] = mk(0, 0, 0, 32'h0,        0, 32'h0,    1, 32'h48,       0, 1, 1, 32'h40,       32'h1010,      0, 32'h0);
    vecs[16] = mk(0, 1, 0, 32'h0,        1, 32'h20,   1, 32'h20,       1, 1, 1, 32'h44,       32'h1011,      0, 32'h0);
    vecs[17] = mk(0, 0, 0, 32'h0,        0, 32'h0,    0, 32'h0,        0, 1, 1, 32'h44,       32'h1011,      1, 32'h1008);
    vecs[18] = mk(0, 0, 0, 32'h0,        0, 32'h0,    1, 32'h4C,       0, 1, 1, 32'h48,       32'h1012,      0, 32'h0);
    vecs[19] = mk(0, 0, 0, 32'h0,        0, 32'h0,    1, 32'h50,       0, 1, 0, 32'h0,        32'h0,         0, 32'h0);
    vecs[20] = mk(0, 0, 0, 32'h0,        0, 32'h0,    1, 32'h54,       0, 1, 1, 32'h4C,       32'h1013,      0, 32'h0);

    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("init");

    foreach (vecs[i]) apply(vecs[i], $sformatf("v%0d", i));

    // The debug request is held while fetch is busy. The grant is forced on the 9th cycle.
    for (int i = 0; i < 9; i++) begin
      apply(mk(0, 0, 0, 32'h0, 1, 32'h100,
               1, (i == 8) ? 32'h100 : 32'h58 + 32'(4 * i), (i == 8),
               1, 1, 32'h50 + 32'(4 * i), 32'h1014 + 32'(i), 0, 32'h0),
            $sformatf("dbgwait%0d", i));
    end
    apply(mk(0, 0, 0, 32'h0, 0, 32'h0, 1, 32'h78, 0, 1, 1, 32'h74, 32'h101D, 1, 32'h1040), "dbgdone");
    apply(mk(0, 0, 0, 32'h0, 0, 32'h0, 1, 32'h7C, 0, 1, 0, 32'h0,  32'h0,    0, 32'h0),    "dbgbubble");
    apply(mk(0, 0, 0, 32'h0, 0, 32'h0, 1, 32'h80, 0, 1, 1, 32'h78, 32'h101E, 0, 32'h0),    "dbgresume");

    // Skid fills while a debug read is in flight, then reset hits.
    apply(mk(0, 1, 0, 32'h0, 1, 32'h30, 1, 32'h30, 1, 1, 1, 32'h7C, 32'h101F, 0, 32'h0),   "preRst");
    apply(mk(1, 0, 0, 32'h0, 0, 32'h0,  0, 32'h0,  0, 0, 0, 32'h0,  32'h0,    0, 32'h0),   "midRst");
    chk_reset_state("mid");
    apply(mk(0, 0, 0, 32'h0, 0, 32'h0, 1, 32'h0, 0, 1, 0, 32'h0, 32'h0,    0, 32'h0), "restart0");
    apply(mk(0, 0, 0, 32'h0, 0, 32'h0, 1, 32'h4, 0, 1, 0, 32'h0, 32'h0,    0, 32'h0), "restart1");
    apply(mk(0, 0, 0, 32'h0, 0, 32'h0, 1, 32'h8, 0, 1, 1, 32'h0, 32'h1000, 0, 32'h0), "restart2");

    // PC wraps from 0xFFFF_FFFC to 0x0.
    apply(mk(0, 0, 1, 32'hFFFF_FFFB, 0, 32'h0, 0, 32'h0,        0, 1, 1, 32'h4,         32'h1001,      0, 32'h0), "wrap0");
    apply(mk(0, 0, 0, 32'h0,         0, 32'h0, 1, 32'hFFFF_FFF8, 0, 1, 0, 32'h0,         32'h0,         0, 32'h0), "wrap1");
    apply(mk(0, 0, 0, 32'h0,         0, 32'h0, 1, 32'hFFFF_FFFC, 0, 1, 0, 32'h0,         32'h0,         0, 32'h0), "wrap2");
    apply(mk(0, 0, 0, 32'h0,         0, 32'h0, 1, 32'h0,        0, 1, 1, 32'hFFFF_FFF8, 32'h4000_0FFE, 0, 32'h0), "wrap3");
    apply(mk(0, 0, 0, 32'h0,         0, 32'h0, 1, 32'h4,        0, 1, 1, 32'hFFFF_FFFC, 32'h4000_0FFF, 0, 32'h0), "wrap4");
    apply(mk(0, 0, 0, 32'h0,         0, 32'h0, 1, 32'h8,        0, 1, 1, 32'h0,         32'h1000,      0, 32'h0), "wrap5");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_fetch_controller.md
# imem_fetch_controller

Sequences the word-addressed, single-read-port instruction memory for the IF stage: maintains the fetch PC, issues one read per cycle, absorbs downstream stalls with a one-entry skid buffer, and flushes on branch/jump redirect. It also arbitrates the same read port for a debug/loader read requester, guaranteeing bounded wait. It sits between the instruction memory and the IF/ID pipeline register. The memory it drives has a registered, synchronous read with 1-cycle latency.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- DBG_MAX_WAIT, 8, cycles a pending debug request may be refused before it is forced through (≥1)
- Clk  in  1  clock; all state updates on rising edge
- Rst  in  1  synchronous, active-high reset
- Stall  in  1  downstream cannot accept; hold output registers
- Redirect  in  1  branch/jump taken; flush and refetch
- RedirectTarget  in  32  new PC; bits [1:0] ignored (forced 00)
- ImemAddress  out  32  read address to memory; bits [1:0] always 00
- ImemReadEn  out  1  read issued this cycle
- ImemInstruction  in  32  read data, valid the cycle after ImemReadEn
- Instruction  out  32  registered fetched instruction to IF/ID
- PCOut  out  32  address of Instruction
- PCPlus4  out  32  PCOut + 4 (mod 2^32)
- InstrValid  out  1  Instruction/PCOut valid
- DbgReq  in  1  debug read request; held until granted
- DbgAddr  in  32  debug read address
- DbgGrant  out  1  debug owns port this cycle (combinational)
- DbgData  out  32  debug read data
- DbgValid  out  1  DbgData valid; one cycle, the cycle after DbgGrant

## Operation
- State: fetch_pc, inflight (valid, pc, squash), skid (valid, instr, pc), output registers, debug wait counter, debug inflight flag.
- Fetch issue condition (cycle t): !Rst && !Redirect && !Stall && !skid.valid && !DbgGrant. On issue: ImemReadEn=1, ImemAddress=fetch_pc, fetch_pc<=fetch_pc+4, inflight<=(1, fetch_pc, 0).
- Response (cycle t+1), not squashed: if !Stall, output regs<=(ImemInstruction, inflight.pc), InstrValid<=1; if Stall, skid<=(ImemInstruction, inflight.pc), outputs hold.
- Stall high with no response: outputs and skid hold. Stall low, skid full: outputs<=skid, skid cleared (no issue that cycle, bubble follows). Stall low, nothing arriving, skid empty: InstrValid<=0.
- Redirect (priority over everything incl. Stall): fetch_pc<={RedirectTarget[31:2],2'b00}; inflight marked squash (its data dropped); skid cleared; InstrValid<=0; no fetch issue that cycle.
- Debug arbitration: DbgGrant=DbgReq && !Rst && (fetch would not otherwise issue || wait counter == DBG_MAX_WAIT). When granted, ImemReadEn=1, ImemAddress={DbgAddr[31:2],00}, fetch suppressed that cycle, fetch_pc unchanged. Next cycle DbgValid=1, DbgData=ImemInstruction.
- Wait counter: increments each cycle DbgReq && !DbgGrant (saturating at DBG_MAX_WAIT); cleared on grant or when DbgReq low.
- PC arithmetic modulo 2^32; 32'hFFFF_FFFC fetch is followed by 32'h0000_0000.

## Timing
- Reset (Rst high at an edge): fetch_pc<=RESET_PC; Instruction, PCOut, DbgData<=0; PCPlus4<=4; InstrValid, DbgValid<=0; skid, inflight, debug inflight cleared; wait counter<=0. While Rst high: ImemReadEn=0, DbgGrant=0. Rst mid-operation discards any in-flight data.
- First request in the first cycle Rst is low; InstrValid first high 2 cycles after Rst deasserts.
- Fetch latency: request cycle t → InstrValid visible cycle t+2. Steady-state throughput 1 instruction/cycle with Stall low.
- Redirect in cycle t → target requested t+1 → InstrValid for target at t+3; InstrValid low at t+1 and t+2.
- Stall release with skid full: skid entry visible next cycle, then one bubble before next fetched instruction.
- Debug forced grant: at most DBG_MAX_WAIT+1 cycles from DbgReq rise to DbgGrant.

## Test plan
- Reset, RESET_PC=0, Stall=0 for 6 cycles, memory word k = 0x1000+k → ImemAddress 0,4,8,…; InstrValid from cycle 2; Instruction 0x1000,0x1001,… with PCOut 0,4,8; PCPlus4 = PCOut+4.
- Stall high 3 cycles during streaming → no instruction lost/duplicated; skid captures in-flight word; after release outputs continue in order with exactly one bubble.
- Redirect to 0x0000_0043 with Stall=1 simultaneously → next request address 0x40; squashed word never appears; InstrValid low 2 cycles; PCOut=0x40 with mem[16].
- DbgReq at 0x20 while Stall=1 → DbgGrant same cycle, DbgValid next cycle with mem[8]; fetch_pc unchanged.
- DbgReq held with Stall=0, DBG_MAX_WAIT=8 → grant on 9th cycle; one fetch bubble; fetch sequence otherwise unbroken.
- Assert Rst mid-stream with skid full and read in flight → all outputs at reset values next cycle; fetching restarts at RESET_PC; fetch_pc wrap 0xFFFF_FFFC→0x0.
